// File: rtl/mem_port_ctrl.sv
// Burst controller for one memory port: it drives write and read bursts and delays read strobes by RD_LAT.
// Optional overflow reject is enabled by defining MEM_PORT_CTRL_OVF_CHK_EN.
module mem_port_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_len,
   input  logic                  wdat_valid,
   input  logic [DATA_WIDTH-1:0] wdat,
   output logic                  wdat_ready,
   output logic [ADDR_WIDTH-1:0] addr0_b0,
   output logic                  ce0_b0,
   output logic                  we0_b0,
   output logic [DATA_WIDTH-1:0] d0_b0,
   output logic                  reg_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [RD_LAT:0]     L_ONE = 1;
   localparam logic [RD_LAT:0]     L_TOP = L_ONE << RD_LAT;
   localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

   logic [1:0]            r_state;
   logic [1:0]            w_nstate;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [RD_LAT:0]       r_sr;
   logic [RD_LAT:0]       r_lsr;
   logic                  r_wfin;
   logic                  r_busy;
   logic                  r_ce;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_d;
   logic [ADDR_WIDTH-1:0] r_a;

   logic                  w_acc;
   logic                  w_ovf;
   logic                  w_go;
   logic                  w_wbeat;
   logic                  w_rce;
   logic                  w_last;
   logic [RD_LAT:0]       w_snext;
   logic [RD_LAT:0]       w_lnext;
   logic                  w_rdone;

   assign cmd_ready  = (r_state == S_IDLE);
   assign wdat_ready = (r_state == S_WRITE);

   assign w_acc   = cmd_valid && cmd_ready;
   assign w_go    = w_acc && !w_ovf;
   assign w_wbeat = wdat_ready && wdat_valid;
   assign w_rce   = (r_state == S_READ);
   assign w_last  = (r_cnt == '0);

   // Two parallel delay lines: every read strobe, and only the final read strobe.
   assign w_snext = (r_sr << 1) | (w_rce ? L_ONE : '0);
   assign w_lnext = (r_lsr << 1) | ((w_rce && w_last) ? L_ONE : '0);
   assign w_rdone = |(w_lnext & L_TOP);

`ifdef MEM_PORT_CTRL_OVF_CHK_EN
   logic [ADDR_WIDTH:0] w_sum;
   logic                r_err;

   assign w_sum = {1'b0, cmd_addr} + {1'b0, cmd_len};
   assign w_ovf = w_sum[ADDR_WIDTH];
   assign err   = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else if (w_acc && w_ovf) r_err <= 1'b1;
   end
`else
   assign w_ovf = 1'b0;
   assign err   = 1'b0;
`endif

   always_comb begin
      w_nstate = r_state;
      unique case (r_state)
         S_IDLE:  if (w_go) w_nstate = cmd_we ? S_WRITE : S_READ;
         S_WRITE: if (w_wbeat && w_last) w_nstate = S_IDLE;
         S_READ:  if (w_last) w_nstate = w_rdone ? S_IDLE : S_DRAIN;
         S_DRAIN: if (w_rdone) w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_sr    <= '0;
         r_lsr   <= '0;
         r_wfin  <= 1'b0;
         r_busy  <= 1'b0;
         r_ce    <= 1'b0;
         r_we    <= 1'b0;
         r_d     <= '0;
         r_a     <= '0;
      end else begin
         r_state <= w_nstate;
         r_busy  <= (w_nstate != S_IDLE);
         r_sr    <= w_snext;
         // Write completion and rejected commands join done at the output stage.
         r_lsr   <= w_lnext | ((r_wfin || (w_acc && w_ovf)) ? L_TOP : '0);
         r_wfin  <= w_wbeat && w_last;
         r_ce    <= w_wbeat || w_rce;
         r_we    <= w_wbeat;
         if (w_wbeat) r_d <= wdat;
         if (w_wbeat || w_rce) r_a <= r_addr;
         if (w_go) begin
            r_addr <= cmd_addr;
            r_cnt  <= cmd_len;
         end else if (w_wbeat || w_rce) begin
            r_addr <= r_addr + A_ONE;
            r_cnt  <= r_cnt - A_ONE;
         end
      end
   end

   assign addr0_b0 = r_a;
   assign ce0_b0   = r_ce;
   assign we0_b0   = r_we;
   assign d0_b0    = r_d;
   assign reg_en   = r_sr[RD_LAT];
   assign busy     = r_busy;
   assign done     = r_lsr[RD_LAT];

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: write/read bursts, gapped writes, wrap, reset abort.
// Overflow expectations follow MEM_PORT_CTRL_OVF_CHK_EN when defined.
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_len;
   logic        wdat_valid;
   logic [31:0] wdat;
   logic        wdat_ready;
   logic [7:0]  addr0_b0;
   logic        ce0_b0;
   logic        we0_b0;
   logic [31:0] d0_b0;
   logic        reg_en;
   logic        busy;
   logic        done;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_ctrl #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(8),
      .RD_LAT(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_we(cmd_we),
      .cmd_addr(cmd_addr),
      .cmd_len(cmd_len),
      .wdat_valid(wdat_valid),
      .wdat(wdat),
      .wdat_ready(wdat_ready),
      .addr0_b0(addr0_b0),
      .ce0_b0(ce0_b0),
      .we0_b0(we0_b0),
      .d0_b0(d0_b0),
      .reg_en(reg_en),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic we, input logic [7:0] a,
                      input logic [7:0] l);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_len   = l;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic [4:0]  pat;
      logic [7:0]  ea;
      int          nce;

      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_we     = 1'b0;
      cmd_addr   = '0;
      cmd_len    = '0;
      wdat_valid = 1'b0;
      wdat       = '0;
      #3;
      chk("rst_ce", ce0_b0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_regen", reg_en, 0);
      chk("rst_cmdrdy", cmd_ready, 1);
      chk("rst_wrdy", wdat_ready, 0);
      chk("rst_err", err, 0);
      #9 rst_n = 1'b1;
      tick();

      // single-beat write
      cmd(1'b1, 8'h01, 8'h00);
      chk("w1_wrdy", wdat_ready, 1);
      chk("w1_busy", busy, 1);
      chk("w1_cmdrdy", cmd_ready, 0);
      chk("w1_ce_pre", ce0_b0, 0);
      wdat_valid = 1'b1;
      wdat       = 32'h1;
      tick();
      wdat_valid = 1'b0;
      chk("w1_ce", ce0_b0, 1);
      chk("w1_we", we0_b0, 1);
      chk("w1_addr", addr0_b0, 8'h01);
      chk("w1_d", d0_b0, 32'h1);
      chk("w1_done_early", done, 0);
      chk("w1_regen", reg_en, 0);
      tick();
      chk("w1_done", done, 1);
      chk("w1_ce_off", ce0_b0, 0);
      chk("w1_regen2", reg_en, 0);
      tick();
      chk("w1_done_off", done, 0);

      // four-beat read, RD_LAT=1
      cmd(1'b0, 8'h01, 8'h03);
      chk("r4_busy", busy, 1);
      chk("r4_ce_pre", ce0_b0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("r4_ce", ce0_b0, 1);
         chk("r4_we", we0_b0, 0);
         chk("r4_addr", addr0_b0, 64'(1 + i));
         chk("r4_regen", reg_en, (i > 0) ? 1 : 0);
         chk("r4_done", done, 0);
      end
      tick();
      chk("r4_ce_off", ce0_b0, 0);
      chk("r4_regen_last", reg_en, 1);
      chk("r4_done_last", done, 1);
      chk("r4_busy_off", busy, 0);
      tick();
      chk("r4_regen_off", reg_en, 0);
      chk("r4_done_off", done, 0);

      // gapped write
      cmd(1'b1, 8'h05, 8'h02);
      pat = 5'b10101;
      nce = 0;
      for (int k = 0; k < 5; k++) begin
         chk("wg_wrdy", wdat_ready, 1);
         wdat_valid = pat[k];
         wdat       = 32'hA0 + 32'(k);
         tick();
         chk("wg_ce", ce0_b0, pat[k]);
         if (pat[k]) begin
            chk("wg_addr", addr0_b0, 64'(5 + nce));
            chk("wg_d", d0_b0, 64'(32'hA0 + k));
            nce++;
         end
      end
      wdat_valid = 1'b0;
      chk("wg_wrdy_off", wdat_ready, 0);
      tick();
      chk("wg_done", done, 1);
      chk("wg_ce_off", ce0_b0, 0);
      tick();

      // read across the top of the address space
      cmd(1'b0, 8'hFE, 8'h03);
`ifdef MEM_PORT_CTRL_OVF_CHK_EN
      chk("ov_ce", ce0_b0, 0);
      chk("ov_err", err, 1);
      chk("ov_done", done, 1);
      chk("ov_busy", busy, 0);
      tick();
      chk("ov_ce2", ce0_b0, 0);
      chk("ov_err_sticky", err, 1);
      chk("ov_done_off", done, 0);
      chk("ov_regen", reg_en, 0);
`else
      for (int i = 0; i < 4; i++) begin
         tick();
         ea = 8'hFE + 8'(i);
         chk("wr_ce", ce0_b0, 1);
         chk("wr_addr", addr0_b0, ea);
         chk("wr_err", err, 0);
      end
      tick();
      chk("wr_done", done, 1);
      chk("wr_regen", reg_en, 1);
`endif
      tick();

      // reset during beat 2 of a four-beat read
      cmd(1'b0, 8'h10, 8'h03);
      tick();
      chk("ra_b1", addr0_b0, 8'h10);
      tick();
      chk("ra_b2", addr0_b0, 8'h11);
      chk("ra_b2_regen", reg_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ra_ce", ce0_b0, 0);
      chk("ra_regen", reg_en, 0);
      chk("ra_busy", busy, 0);
      chk("ra_addr", addr0_b0, 0);
      chk("ra_done", done, 0);
      chk("ra_err", err, 0);
      chk("ra_cmdrdy", cmd_ready, 1);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ra_post_ce", ce0_b0, 0);
         chk("ra_post_regen", reg_en, 0);
         chk("ra_post_done", done, 0);
      end
      chk("ra_cmdrdy2", cmd_ready, 1);
      cmd(1'b1, 8'h20, 8'h00);
      wdat_valid = 1'b1;
      wdat       = 32'h55;
      tick();
      wdat_valid = 1'b0;
      chk("ra_next_ce", ce0_b0, 1);
      chk("ra_next_addr", addr0_b0, 8'h20);
      chk("ra_next_d", d0_b0, 32'h55);
      tick();
      chk("ra_next_done", done, 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, memory address width; cmd_len has the same width.
REQ-003 SHALL have parameter RD_LAT, default 1, legal 0..3, cycles from read ce0_b0 to reg_en.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  burst command offered.
REQ-007 cmd_ready  output  1  controller can accept a command (high only in IDLE).
REQ-008 cmd_we  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  input  ADDR_WIDTH  start address.
REQ-010 cmd_len  input  ADDR_WIDTH  beats minus one (0 = 1 beat).
REQ-011 wdat_valid  input  1  write-data beat offered.
REQ-012 wdat  input  DATA_WIDTH  write-data beat.
REQ-013 wdat_ready  output  1  beat accepted this cycle (high only in WRITE).
REQ-014 addr0_b0, ce0_b0, we0_b0, d0_b0  output  ADDR_WIDTH/1/1/DATA_WIDTH  memory bank-0 port 0 drive.
REQ-015 reg_en  output  1  capture strobe for the downstream output register.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse at burst completion.
REQ-018 err  output  1  sticky address-overflow flag (see Configuration).

Function
REQ-019 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-020 IDLE: on cmd_valid&cmd_ready SHALL latch addr, len, we; go WRITE if cmd_we else READ.
REQ-021 WRITE: each cycle with wdat_valid SHALL drive ce0_b0=1, we0_b0=1, d0_b0=wdat, addr0_b0=current address; cycles without wdat_valid SHALL drive ce0_b0=0.
REQ-022 READ: SHALL issue one beat per cycle, ce0_b0=1, we0_b0=0, no stalls.
REQ-023 After each beat address SHALL increment by 1 modulo 2^ADDR_WIDTH and beat counter SHALL decrement.
REQ-024 After the final write beat SHALL go IDLE and pulse done in the next cycle.
REQ-025 After the final read beat SHALL go DRAIN, stay until the reg_en pipeline is empty, then go IDLE with done pulse in the same cycle as the last reg_en (RD_LAT=0: same cycle as last ce).
REQ-026 reg_en SHALL equal read-ce0_b0 delayed by RD_LAT cycles via a shift register; never asserted for writes.
REQ-027 Outputs SHALL be registered except cmd_ready and wdat_ready, which decode state only.
REQ-028 cmd_valid outside IDLE SHALL be ignored; wdat_valid outside WRITE SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear counters, reg_en pipeline, err, and drive all outputs 0 except cmd_ready=1 once released.
REQ-030 Reset mid-burst SHALL abort without further ce0_b0 or done; no pending reg_en survives.

Configuration
REQ-031 Macro MEM_PORT_CTRL_OVF_CHK_EN: when defined, a command with cmd_addr+cmd_len > 2^ADDR_WIDTH-1 SHALL be accepted but not executed: no ce0_b0, err set sticky until reset, done pulsed next cycle.
REQ-032 When undefined, such bursts SHALL execute with address wrap to 0 and err SHALL be constant 0.

Verification
REQ-033 Write addr=1, len=0, wdat=0x1 -> one cycle ce0_b0=1, we0_b0=1, addr0_b0=1, d0_b0=0x1; done next cycle; no reg_en.
REQ-034 Read addr=1, len=3, RD_LAT=1 -> ce0_b0 4 cycles with addr 1,2,3,4; reg_en 4 cycles starting one cycle later; done with last reg_en.
REQ-035 Write len=2 with wdat_valid gapped 1,0,1,0,1 -> exactly 3 ce0_b0 pulses on addr 5,6,7, wdat_ready high throughout WRITE.
REQ-036 Read addr=0xFE, len=3: macro off -> addrs FE,FF,00,01; macro on -> no ce0_b0, err=1, done pulse.
REQ-037 rst_n low during beat 2 of 4-beat read -> all outputs 0 immediately, no reg_en or done after release, next command accepted normally.
